obstacle_spawn_sched: RTL
=========================

# obstacle_spawn_sched

Per-frame scheduler that owns the life cycle of the four on-screen obstacle slots: it retires a slot on a bullet hit or a bottom escape, holds it in a respawn cooldown, and grants at most one respawn per frame round-robin with a pseudo-random X position and a level-dependent fall speed. It sits between the ammo/obstacle collision datapath and the obstacle position registers, and also produces score, level and miss events for the HUD and game-state FSM.

## Interface
- NUM_SLOTS, 4, obstacle slots; index width 2.
- RESPAWN_DELAY, 30, frames a retired slot waits before it becomes READY; legal range 1..255.
- X_MIN, 5, leftmost spawn X.
- X_MAX, 606, rightmost spawn X; SPAN = X_MAX-X_MIN must be 511..1022.
- Y_SPAWN, 3, spawn Y.
- Y_BOTTOM, 446, escape threshold on obstacle top-left Y (476 minus 30-pixel size).
- KILLS_PER_LEVEL, 8, hits per level increment; legal range 1..255.
- MAX_SPEED, 7, speed ceiling; legal range 1..7.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- frame_clk  in  1  frame clock; single clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  game running; when low the block freezes.
- hit_valid  in  1  one-frame collision report from the datapath.
- hit_idx  in  2  slot that was hit.
- obj_y[4]  in  10 each  current obstacle Y, per slot.
- slot_active[4]  out  1 each  slot is falling and collidable.
- spawn_valid  out  1  one-frame spawn command.
- spawn_idx  out  2  slot being spawned.
- spawn_x  out  10  spawn X.
- spawn_y  out  10  spawn Y; always Y_SPAWN.
- spawn_speed  out  3  pixels per frame for the new obstacle.
- miss_pulse  out  1  one-frame pulse when any slot escapes the bottom.
- score  out  16  hit count; saturates at 16'hFFFF.
- level  out  4  difficulty level; saturates at 15.

## Operation
- Per-slot FSM with states READY, ACTIVE and COOLDOWN, plus an 8-bit counter cnt[i].
  - READY -> ACTIVE when the slot is granted a spawn.
  - ACTIVE -> COOLDOWN on a hit (hit_valid && hit_idx==i) or an escape (obj_y[i] >= Y_BOTTOM). On entry, cnt <= RESPAWN_DELAY.
  - COOLDOWN: each enabled edge, if cnt==1 go to READY, else decrement cnt.
- Hit and escape on the same slot in the same frame: the hit wins. Score is credited and no miss_pulse is raised.
- hit_valid targeting a slot that is not ACTIVE is ignored, with no score change.
- Escapes on several slots in one frame produce a single miss_pulse.
- Escape check is suppressed for slot i in the frame its spawn_valid is high, because obj_y has not reloaded yet.
- Arbiter grants one READY slot per frame.
  - Search order is rr_ptr, rr_ptr+1, ... mod 4.
  - On a grant, rr_ptr <= spawn_idx+1 mod 4.
  - No READY slot means spawn_valid=0 and rr_ptr holds.
- LFSR is 16-bit Galois, mask 16'hB400, and advances every enabled edge.
  - Let r = lfsr[9:0].
  - If r > SPAN, then spawn_x = X_MIN + r - SPAN - 1; otherwise spawn_x = X_MIN + r.
  - spawn_x is always within X_MIN..X_MAX.
- spawn_speed = min(1+level, MAX_SPEED), computed from level before any same-edge update.
- A kill counter increments on each credited hit.
  - On reaching KILLS_PER_LEVEL it clears and level increments, saturating at 15.
  - score increments on each credited hit, saturating.
- enable low:
  - no state changes: FSMs, cnt, rr_ptr, LFSR, score and level all hold;
  - hits are ignored;
  - spawn_valid=0 and miss_pulse=0.

## Timing
- All outputs are registered on posedge frame_clk.
- Reset_n low asynchronously sets:
  - every slot to READY, with slot_active=0 and cnt=0;
  - rr_ptr=0, lfsr=LFSR_SEED;
  - score=0, level=0, kill counter=0;
  - spawn_valid=0, spawn_idx=0, spawn_x=0, spawn_y=0, spawn_speed=0, miss_pulse=0.
- Reset asserted mid-operation discards all cooldowns and active slots immediately.
- After release with enable=1, slots 0, 1, 2 and 3 spawn on the 1st, 2nd, 3rd and 4th edges respectively.
- spawn_valid, spawn_idx, spawn_x, spawn_y and spawn_speed are high/valid for exactly one cycle.
  - slot_active[spawn_idx] rises on the same edge.
  - The obstacle datapath loads position and speed on the following edge.
- Hit or escape sampled at edge k:
  - slot_active falls, and score/level/miss_pulse update, after edge k;
  - the slot is READY after edge k+RESPAWN_DELAY;
  - the earliest respawn is at edge k+RESPAWN_DELAY+1.
- Decision latency from any input to a registered output is one frame.

## Test plan
- Reset release, enable=1, no hits -> spawn_idx 0,1,2,3 on edges 1..4; slot_active=4'b1111 after edge 4; spawn_speed=1; spawn_x matches the LFSR model from seed ACE1.
- hit_valid=1, hit_idx=2 at edge k -> slot_active[2]=0 and score=1 after edge k; slot 2 respawns at edge k+31; no other slot is affected.
- obj_y[1]=446 while active and no hit -> one miss_pulse; score unchanged; slot 1 goes to COOLDOWN. The same frame with hit_idx=1 -> score+1 and no miss_pulse.
- 8 credited hits -> level=1 and spawn_speed=2; after 6 more levels spawn_speed stays at 7; the score counter preloaded at FFFF stays at FFFF.
- Sweep 2000 spawns -> every spawn_x is within 5..606; hits on inactive slots never change score.
- enable low for 10 frames mid-cooldown, then high -> cnt resumes from its frozen value; no spawn_valid during the low window. Reset_n pulsed mid-game -> all outputs reach their reset values immediately.

Source files
------------

// File: rtl/obstacle_spawn_sched_if.sv
// Bus between the obstacle collision datapath and the spawn scheduler.
// The slave side is the scheduler; the master side is the datapath/HUD.
interface obstacle_spawn_sched_if;
  logic       hit_valid;
  logic [1:0] hit_idx;
  logic [9:0] obj_y [4];
  logic [3:0] slot_active;
  logic       spawn_valid;
  logic [1:0] spawn_idx;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [2:0] spawn_speed;
  logic       miss_pulse;
  logic [15:0] score;
  logic [3:0] level;

  modport master (
    output hit_valid, hit_idx, obj_y,
    input  slot_active, spawn_valid, spawn_idx, spawn_x, spawn_y, spawn_speed,
           miss_pulse, score, level
  );

  modport slave (
    input  hit_valid, hit_idx, obj_y,
    output slot_active, spawn_valid, spawn_idx, spawn_x, spawn_y, spawn_speed,
           miss_pulse, score, level
  );
endinterface

// File: rtl/obstacle_spawn_sched.sv
// Per-frame obstacle slot life cycle: retire on hit/escape, cooldown, one
// round-robin respawn per frame with LFSR X position; also score/level/miss.
module obstacle_spawn_sched #(
  parameter int          NUM_SLOTS       = 4,
  parameter int          RESPAWN_DELAY   = 30,
  parameter int          X_MIN           = 5,
  parameter int          X_MAX           = 606,
  parameter int          Y_SPAWN         = 3,
  parameter int          Y_BOTTOM        = 446,
  parameter int          KILLS_PER_LEVEL = 8,
  parameter int          MAX_SPEED       = 7,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic                  enable,
  obstacle_spawn_sched_if.slave bus
);

  localparam logic [7:0]  DELAY_V     = 8'(RESPAWN_DELAY);
  localparam logic [9:0]  X_MIN_V     = 10'(X_MIN);
  localparam logic [9:0]  SPAN_V      = 10'(X_MAX - X_MIN);
  localparam logic [9:0]  SPAN_P1_V   = 10'(X_MAX - X_MIN + 1);
  localparam logic [9:0]  Y_SPAWN_V   = 10'(Y_SPAWN);
  localparam logic [9:0]  Y_BOTTOM_V  = 10'(Y_BOTTOM);
  localparam logic [7:0]  KPL_V       = 8'(KILLS_PER_LEVEL);
  localparam logic [4:0]  MAX_SPEED_V = 5'(MAX_SPEED);
  localparam logic [15:0] LFSR_MASK   = 16'hB400;

  typedef enum logic [1:0] {READY, ACTIVE, COOLDOWN} slot_state_t;

  logic [NUM_SLOTS-1:0] ready_vec;
  logic [NUM_SLOTS-1:0] active_vec;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [NUM_SLOTS-1:0] escape_vec;
  logic [NUM_SLOTS-1:0] grant_vec;

  logic        spawn_valid_reg;
  logic [1:0]  spawn_idx_reg;
  logic [9:0]  spawn_x_reg;
  logic [9:0]  spawn_y_reg;
  logic [2:0]  spawn_speed_reg;
  logic        miss_pulse_reg;
  logic [15:0] score_reg;
  logic [3:0]  level_reg;
  logic [7:0]  kill_reg;
  logic [1:0]  rr_ptr_reg;
  logic [15:0] lfsr_reg;

  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic [15:0] lfsr_next;
  logic [9:0]  x_next;
  logic [2:0]  speed_next;
  logic [4:0]  level_p1;
  logic [7:0]  kill_next;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      slot_state_t state_reg;
      logic [7:0]  cnt_reg;
      logic        active_reg;

      assign ready_vec[gi]  = (state_reg == READY);
      assign active_vec[gi] = active_reg;
      assign hit_vec[gi]    = bus.hit_valid && (bus.hit_idx == 2'(gi)) &&
                              (state_reg == ACTIVE);
      // obj_y still holds the old position in the frame right after a spawn
      assign escape_vec[gi] = (state_reg == ACTIVE) && (bus.obj_y[gi] >= Y_BOTTOM_V) &&
                              !(spawn_valid_reg && (spawn_idx_reg == 2'(gi)));
      assign grant_vec[gi]  = grant_found && (grant_idx == 2'(gi));

      always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
          state_reg  <= READY;
          cnt_reg    <= 8'd0;
          active_reg <= 1'b0;
        end else if (enable) begin
          case (state_reg)
            READY: begin
              if (grant_vec[gi]) begin
                state_reg  <= ACTIVE;
                active_reg <= 1'b1;
              end
            end
            ACTIVE: begin
              if (hit_vec[gi] || escape_vec[gi]) begin
                state_reg  <= COOLDOWN;
                cnt_reg    <= DELAY_V;
                active_reg <= 1'b0;
              end
            end
            COOLDOWN: begin
              if (cnt_reg == 8'd1) state_reg <= READY;
              else                 cnt_reg   <= cnt_reg - 8'd1;
            end
            default: begin
              state_reg  <= READY;
              active_reg <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cand = rr_ptr_reg + 2'(k);
      if (!grant_found && ready_vec[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Values of r above SPAN fold back to the left edge; 10-bit wrap is exact here
  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
    if (lfsr_reg[9:0] > SPAN_V) x_next = X_MIN_V + lfsr_reg[9:0] - SPAN_P1_V;
    else                        x_next = X_MIN_V + lfsr_reg[9:0];
    level_p1   = {1'b0, level_reg} + 5'd1;
    speed_next = (level_p1 > MAX_SPEED_V) ? MAX_SPEED_V[2:0] : level_p1[2:0];
    kill_next  = kill_reg + 8'd1;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_valid_reg <= 1'b0;
      spawn_idx_reg   <= 2'd0;
      spawn_x_reg     <= 10'd0;
      spawn_y_reg     <= 10'd0;
      spawn_speed_reg <= 3'd0;
      miss_pulse_reg  <= 1'b0;
      score_reg       <= 16'd0;
      level_reg       <= 4'd0;
      kill_reg        <= 8'd0;
      rr_ptr_reg      <= 2'd0;
      lfsr_reg        <= LFSR_SEED;
    end else if (!enable) begin
      spawn_valid_reg <= 1'b0;
      miss_pulse_reg  <= 1'b0;
    end else begin
      lfsr_reg        <= lfsr_next;
      spawn_valid_reg <= grant_found;
      if (grant_found) begin
        spawn_idx_reg   <= grant_idx;
        spawn_x_reg     <= x_next;
        spawn_y_reg     <= Y_SPAWN_V;
        spawn_speed_reg <= speed_next;
        rr_ptr_reg      <= grant_idx + 2'd1;
      end
      // A hit on a slot outranks its own escape in the same frame
      miss_pulse_reg <= |(escape_vec & ~hit_vec);
      if (|hit_vec) begin
        if (score_reg != 16'hFFFF) score_reg <= score_reg + 16'd1;
        if (kill_next == KPL_V) begin
          kill_reg <= 8'd0;
          if (level_reg != 4'd15) level_reg <= level_reg + 4'd1;
        end else begin
          kill_reg <= kill_next;
        end
      end
    end
  end

  assign bus.slot_active = active_vec;
  assign bus.spawn_valid = spawn_valid_reg;
  assign bus.spawn_idx   = spawn_idx_reg;
  assign bus.spawn_x     = spawn_x_reg;
  assign bus.spawn_y     = spawn_y_reg;
  assign bus.spawn_speed = spawn_speed_reg;
  assign bus.miss_pulse  = miss_pulse_reg;
  assign bus.score       = score_reg;
  assign bus.level       = level_reg;

endmodule
